// File: rtl/toy_mem_pkg.sv
// Shared types and constants for the TOY data-memory request path.
// Holds the op_kind encoding, default widths and the request FSM states.
package toy_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] OP_LD_DIR = 2'b00;
    localparam logic [1:0] OP_LD_IND = 2'b01;
    localparam logic [1:0] OP_ST_DIR = 2'b10;
    localparam logic [1:0] OP_ST_IND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RSP  = 2'd2,
        ST_WRITEBACK = 2'd3
    } req_state_e;

    function automatic logic op_is_store(input logic [1:0] kind);
        return kind[1];
    endfunction

    function automatic logic op_is_indirect(input logic [1:0] kind);
        return kind[0];
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Load-response timeout counter: counts enabled cycles since the last clear.
// expired_o is high during the TIMEOUT-th enabled cycle (count == TIMEOUT-1).
module mem_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CMAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_request_master.sv
// Initiator for the TOY data memory: takes one load/store op, issues a valid/ready request,
// waits (bounded by TIMEOUT) for load data and strobes it back to the register file.
module mem_request_master
    import toy_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_kind,
    input  logic [ADDR_W-1:0] op_imm,
    input  logic [DATA_W-1:0] op_areg,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic [3:0]        op_dst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              wb_valid,
    output logic [3:0]        wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              err_timeout
);
    req_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        dst_q, dst_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              expired;

    // Only the low ADDR_W bits of A form an address.
    logic unused_areg_hi;
    assign unused_areg_hi = ^op_areg[DATA_W-1:ADDR_W];

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk),
        .reset_i   (reset),
        .clr_i     (state_q != ST_WAIT_RSP),
        .en_i      (state_q == ST_WAIT_RSP),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dst_d   = dst_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    state_d = ST_ISSUE;
                    we_d    = op_is_store(op_kind);
                    addr_d  = op_is_indirect(op_kind) ? op_areg[ADDR_W-1:0] : op_imm;
                    wdata_d = op_is_store(op_kind) ? op_wdata : '0;
                    dst_d   = op_dst;
                    err_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = we_q ? ST_IDLE : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // A response in the final allowed cycle beats the timeout.
                if (mem_rsp_valid) begin
                    rdata_d = mem_rsp_rdata;
                    state_d = ST_WRITEBACK;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dst_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dst_q   <= dst_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign op_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign wb_valid      = (state_q == ST_WRITEBACK);
    assign wb_dst        = dst_q;
    assign wb_data       = rdata_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_mem_request_master.sv
// Randomized scoreboard bench for mem_request_master: expected requests and writebacks are queued
// by the stimulus side and consumed by an independent monitor sampling on the falling edge.
module tb_mem_request_master;
    localparam int TO = 15;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct packed {
        logic [3:0]  dst;
        logic [15:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_kind;
    logic [11:0] op_imm;
    logic [15:0] op_areg;
    logic [15:0] op_wdata;
    logic [3:0]  op_dst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [11:0] mem_req_addr;
    logic [15:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_rdata;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        busy;
    logic        err_timeout;

    int tests = 0;
    int fails = 0;
    req_t req_q[$];
    wb_t  wb_q[$];

    always #5 clk = ~clk;

    mem_request_master #(
        .ADDR_W  (12),
        .DATA_W  (16),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_kind       (op_kind),
        .op_imm        (op_imm),
        .op_areg       (op_areg),
        .op_wdata      (op_wdata),
        .op_dst        (op_dst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every presented request must match the head of req_q; every wb strobe pops wb_q.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_unexpected: got addr 0x%0h with nothing outstanding", mem_req_addr);
                end else begin
                    check("req_fields", {mem_req_we, mem_req_addr, mem_req_wdata}, req_q[0]);
                    if (mem_req_ready) void'(req_q.pop_front());
                end
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb_unexpected: got dst %0d data 0x%0h with none expected", wb_dst, wb_data);
                end else begin
                    check("wb_fields", {wb_dst, wb_data}, wb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {op_ready, busy, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
                     wb_valid, wb_dst, wb_data, err_timeout},
              {1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0});
    endtask

    // Reference: address/data from op_kind rules; outcome from dly vs TO (dly = WAIT_RSP cycle of rsp).
    task automatic do_op(input logic [1:0] kind, input logic [11:0] imm, input logic [15:0] areg,
                         input logic [15:0] wdata, input logic [3:0] dst, input int stall,
                         input int dly, input logic [15:0] rdata, input bit spur_hs);
        bit          is_ld;
        logic [11:0] ea;
        int          n;
        is_ld = (kind == 2'b00) || (kind == 2'b01);
        ea    = (kind == 2'b01 || kind == 2'b11) ? (areg & 16'h0FFF) : imm;
        n = 0;
        while (!op_ready && n < 50) begin
            tick();
            n++;
        end
        if (!op_ready) begin
            tests++;
            fails++;
            $display("FAIL op_ready_wait: got 0 expected 1 within 50 cycles");
        end
        op_valid      = 1'b1;
        op_kind       = kind;
        op_imm        = imm;
        op_areg       = areg;
        op_wdata      = wdata;
        op_dst        = dst;
        mem_rsp_valid = spur_hs;
        mem_rsp_rdata = 16'hDEAD;
        req_q.push_back('{we: !is_ld, addr: ea, wdata: is_ld ? 16'h0 : wdata});
        tick();
        op_valid      = 1'b0;
        mem_rsp_valid = 1'b0;
        check("issue_op_ready", op_ready, 0);
        check("hs_clears_err", err_timeout, 0);
        for (int i = 0; i < stall; i++) begin
            mem_req_ready = 1'b0;
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        if (!is_ld) begin
            check("st_op_ready_next", op_ready, 1);
            return;
        end
        check("ld_wait_busy", busy, 1);
        if (dly <= TO) begin
            for (int k = 1; k < dly; k++) tick();
            wb_q.push_back('{dst: dst, data: rdata});
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            tick();
            mem_rsp_valid = 1'b0;
            check("wb_op_ready", op_ready, 0);
            tick();
            check("ld_done_ready", op_ready, 1);
            check("ld_no_err", err_timeout, 0);
        end else begin
            for (int k = 1; k <= TO; k++) tick();
            check("timeout_err", err_timeout, 1);
            check("timeout_idle", op_ready, 1);
            // A late response after the abort must not produce a writeback.
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 16'hBAD0;
            tick();
            mem_rsp_valid = 1'b0;
            check("late_rsp_err_kept", err_timeout, 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  st;
        int  dl;
        logic [1:0] kd;
        reset         = 1'b1;
        op_valid      = 1'b0;
        op_kind       = 2'b00;
        op_imm        = '0;
        op_areg       = '0;
        op_wdata      = '0;
        op_dst        = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_idle_outputs("reset_state");

        // Reset in the middle of WAIT_RSP, then a stray response after release.
        op_valid = 1'b1;
        op_kind  = 2'b00;
        op_imm   = 12'h777;
        op_dst   = 4'h5;
        req_q.push_back('{we: 1'b0, addr: 12'h777, wdata: 16'h0});
        tick();
        op_valid      = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("reset_mid_wait");
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 16'h5555;
        tick();
        mem_rsp_valid = 1'b0;
        tick();
        check_idle_outputs("rsp_after_reset");

        // Directed cases.
        do_op(2'b10, 12'h0A5, 16'h0000, 16'h1234, 4'h0, 0, 1, 16'h0, 1'b0);
        do_op(2'b01, 12'h000, 16'hF123, 16'h9999, 4'h3, 4, 2, 16'hBEEF, 1'b0);
        do_op(2'b00, 12'hFFF, 16'h0000, 16'h0000, 4'h7, 0, TO + 1, 16'h0, 1'b0);
        do_op(2'b11, 12'h000, 16'hAFFF, 16'h4321, 4'h0, 1, 1, 16'h0, 1'b0);
        do_op(2'b00, 12'h100, 16'h0000, 16'h0000, 4'h9, 0, TO, 16'hCAFE, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 16'hF00D;
        tick();
        mem_rsp_valid = 1'b0;
        do_op(2'b00, 12'h042, 16'h0000, 16'h0000, 4'hC, 0, 1, 16'h0001, 1'b1);

        // Randomized ops, mostly answered, some timing out, some with stray responses.
        for (int i = 0; i < 150; i++) begin
            kd = 2'($urandom_range(0, 3));
            st = $urandom_range(0, 3);
            dl = ($urandom_range(0, 5) == 0) ? TO + 1 : $urandom_range(1, TO);
            if ($urandom_range(0, 4) == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = 16'($urandom);
                tick();
                mem_rsp_valid = 1'b0;
            end
            do_op(kd, 12'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), st, dl,
                  16'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (3) tick();
        check("req_q_drained", req_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
